ram_fifo: RTL and testbench
===========================

RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 SHALL have parameter Data_width, default 8, bits per stored word.
REQ-002 SHALL have parameter Addr_width, default 10, address bits; depth = 2**Addr_width words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port wr  input  1  write request; push wr_data when accepted.
REQ-006 SHALL have port wr_data  input  Data_width  word to push.
REQ-007 SHALL have port rd  input  1  read request; pop head word when accepted.
REQ-008 SHALL have port rd_data  output  Data_width  popped word, valid when rd_valid=1.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-010 SHALL have port full  output  1  no free entries.
REQ-011 SHALL have port empty  output  1  no stored entries.
REQ-012 SHALL have port count  output  Addr_width+1  number of stored entries, 0..2**Addr_width.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse on write request while full.
REQ-014 SHALL have port rd_err  output  1  one-cycle pulse on read request while empty.

Function
REQ-015 SHALL keep write and read pointers of Addr_width+1 bits each; low Addr_width bits address storage, MSB is the wrap bit.
REQ-016 SHALL assert empty when pointers are equal, full when low bits are equal and MSBs differ; both combinational from registered pointers.
REQ-017 SHALL set count = write pointer minus read pointer, modulo 2**(Addr_width+1).
REQ-018 SHALL accept a write when wr=1 and full=0: store wr_data at write pointer, increment write pointer.
REQ-019 SHALL accept a read when rd=1 and empty=0: increment read pointer; rd_data SHALL hold the popped word, and rd_valid SHALL be 1, in the next cycle only (read latency 1).
REQ-020 SHALL ignore a write while full (no pointer or storage change) and pulse wr_err for one cycle.
REQ-021 SHALL ignore a read while empty (no pointer change, rd_valid stays 0) and pulse rd_err for one cycle.
REQ-022 SHALL, on simultaneous wr and rd with 0<count<depth, accept both; count unchanged.
REQ-023 SHALL, on simultaneous wr and rd while full, accept only the read and pulse wr_err; count becomes depth-1.
REQ-024 SHALL, on simultaneous wr and rd while empty, accept only the write and pulse rd_err; no fall-through, so the word is readable from the next cycle.
REQ-025 SHALL wrap both pointers from 2**(Addr_width+1)-1 to 0 without disturbing flags.
REQ-026 SHALL hold rd_data stable while rd_valid=0 and no read is accepted.

Reset
REQ-027 SHALL, while reset=1, force both pointers to 0, so empty=1, full=0, count=0, and force rd_valid=0, wr_err=0, rd_err=0.
REQ-028 SHALL NOT clear storage contents; rd_data is undefined until the first rd_valid after reset.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored entries and cancel any pending rd_valid.

Structure
REQ-030 SHALL place storage in one sub-module, dp_ram (Data_width, Addr_width), driven as: we = accepted write, w_addr/r_addr = pointer low bits, read data registered inside it.
REQ-031 SHALL keep pointers, flags and error pulses in ram_fifo; no shared package is required, and pointer width SHALL derive from Addr_width only.

Verification
REQ-032 SHALL cover: reset, then write 0x11,0x22,0x33, then three reads -> rd_data 0x11,0x22,0x33, each one cycle after its rd; count goes 3,2,1,0; empty=1 at the end.
REQ-033 SHALL cover: Addr_width=2, write 4 words -> full=1, count=4; a 5th write -> wr_err pulse, count stays 4, and later reads return the first 4 words.
REQ-034 SHALL cover: read while empty -> rd_err pulse, rd_valid=0, count=0.
REQ-035 SHALL cover: with count=2, wr and rd in the same cycle for 10 cycles -> count stays 2 and data order is preserved across pointer wrap.
REQ-036 SHALL cover: simultaneous wr and rd while full -> read data valid, wr_err=1, count=depth-1; simultaneous wr and rd while empty -> rd_err=1, count=1.
REQ-037 SHALL cover: reset asserted between clock edges with count=3 -> empty=1, count=0, rd_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared defaults for the RAM-backed FIFO
package ram_fifo_pkg;
  localparam int DefDataWidth = 8;
  localparam int DefAddrWidth = 10;
endpackage

// File: rtl/ram_fifo_dp_ram.sv
// rtl/ram_fifo_dp_ram.sv - simple dual-port storage with registered read data
// Read data only updates on re so the FIFO output holds between pops.
module dp_ram
  import ram_fifo_pkg::*;
#(
  parameter int Data_width = DefDataWidth,
  parameter int Addr_width = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [Addr_width-1:0] w_addr,
  input  logic [Data_width-1:0] w_data,
  input  logic                  re,
  input  logic [Addr_width-1:0] r_addr,
  output logic [Data_width-1:0] r_data
);

  logic [Data_width-1:0] mem_q [2**Addr_width];
  logic [Data_width-1:0] r_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
    if (re) r_data_q <= mem_q[r_addr];
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/ram_fifo.sv
// rtl/ram_fifo.sv - synchronous FIFO with wrap-bit pointers over a dual-port RAM
// Pointers carry one extra MSB so full and empty are distinguishable without a counter.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int Data_width = DefDataWidth,
  parameter int Addr_width = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [Data_width-1:0] wr_data,
  input  logic                  rd,
  output logic [Data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [Addr_width:0]   count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int PtrW = Addr_width + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            rd_valid_q, wr_err_q, rd_err_q;
  logic            wr_acc, rd_acc;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[Addr_width] != rptr_q[Addr_width]) &&
                 (wptr_q[Addr_width-1:0] == rptr_q[Addr_width-1:0]);
  assign count = wptr_q - rptr_q;

  // Acceptance uses the pre-edge flags, so a full FIFO rejects a write even if a read pops in the same cycle.
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PtrW'(1);
    if (rd_acc) rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_acc;
      wr_err_q   <= wr && full;
      rd_err_q   <= rd && empty;
    end
  end

  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

  dp_ram #(
    .Data_width(Data_width),
    .Addr_width(Addr_width)
  ) u_dp_ram (
    .clk   (clk),
    .we    (wr_acc),
    .w_addr(wptr_q[Addr_width-1:0]),
    .w_data(wr_data),
    .re    (rd_acc),
    .r_addr(rptr_q[Addr_width-1:0]),
    .r_data(rd_data)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// tb/tb_ram_fifo.sv - directed bench for ram_fifo against a queue-based model
module tb_ram_fifo;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, wr, rd;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, full, empty, wr_err, rd_err;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_wr_err, m_rd_err, m_known;
  logic          checking = 1'b0;

  ram_fifo #(.Data_width(DW), .Addr_width(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_valid  = 1'b0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
    m_known  = 1'b0;
  endtask

  // Model outcome of one clock: decisions come from occupancy before the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bit was_full, was_empty;
    wr = w; wr_data = d; rd = r;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_wr_err  = w && was_full;
    m_rd_err  = r && was_empty;
    m_valid   = r && !was_empty;
    if (r && !was_empty) begin
      m_data  = q.pop_front();
      m_known = 1'b1;
    end
    if (w && !was_full) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("m_count",    int'(count),    q.size());
      chk("m_empty",    int'(empty),    int'(q.size() == 0));
      chk("m_full",     int'(full),     int'(q.size() == DEPTH));
      chk("m_rd_valid", int'(rd_valid), int'(m_valid));
      chk("m_wr_err",   int'(wr_err),   int'(m_wr_err));
      chk("m_rd_err",   int'(rd_err),   int'(m_rd_err));
      if (m_known) chk("m_rd_data", int'(rd_data), int'(m_data));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; wr_data = '0;
    model_clear();
    checking = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_count", int'(count), 0);
    reset = 1'b0;

    // basic write three, read three
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
    chk("w3_count", int'(count), 3);
    step(0, 0, 1);
    chk("r1_valid", int'(rd_valid), 1); chk("r1_data", int'(rd_data), 'h11); chk("r1_count", int'(count), 2);
    step(0, 0, 1);
    chk("r2_data", int'(rd_data), 'h22); chk("r2_count", int'(count), 1);
    step(0, 0, 1);
    chk("r3_data", int'(rd_data), 'h33); chk("r3_count", int'(count), 0);
    chk("r3_empty", int'(empty), 1);
    step(0, 0, 0);
    chk("idle_hold", int'(rd_data), 'h33);

    // read while empty
    step(0, 0, 1);
    chk("ue_rd_err", int'(rd_err), 1); chk("ue_valid", int'(rd_valid), 0); chk("ue_count", int'(count), 0);

    // fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) step(1, 8'hA0 + 8'(i), 0);
    chk("full_flag", int'(full), 1); chk("full_count", int'(count), 4);
    step(1, 8'hEE, 0);
    chk("of_wr_err", int'(wr_err), 1); chk("of_count", int'(count), 4);

    // simultaneous while full: read only
    step(1, 8'hB0, 1);
    chk("sf_valid", int'(rd_valid), 1); chk("sf_data", int'(rd_data), 'hA0);
    chk("sf_wr_err", int'(wr_err), 1); chk("sf_count", int'(count), 3);
    step(0, 0, 1); chk("d1", int'(rd_data), 'hA1);
    step(0, 0, 1); chk("d2", int'(rd_data), 'hA2);
    step(0, 0, 1); chk("d3", int'(rd_data), 'hA3);

    // simultaneous while empty: write only, no fall-through
    step(1, 8'hC0, 1);
    chk("se_rd_err", int'(rd_err), 1); chk("se_valid", int'(rd_valid), 0); chk("se_count", int'(count), 1);
    step(0, 0, 1);
    chk("se_data", int'(rd_data), 'hC0);

    // steady state at count=2 across pointer wrap
    step(1, 8'h40, 0); step(1, 8'h41, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h50 + 8'(i), 1);
    chk("ss_count", int'(count), 2);
    chk("ss_last", int'(rd_data), 'h57);

    // reset between edges with count=3 and a pending rd_valid
    step(1, 8'h60, 0);
    step(1, 8'h61, 1);
    chk("pre_rst_valid", int'(rd_valid), 1); chk("pre_rst_count", int'(count), 3);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(rd_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    step(1, 8'h77, 0);
    step(0, 0, 1);
    chk("post_rst_data", int'(rd_data), 'h77);
    step(0, 0, 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
